// File: rtl/ttt_board_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : ttt_board_ctrl
// Purpose  : Tic-tac-toe game controller. Holds the A/B occupancy boards,
//            accepts one move per turn over a valid/ready handshake, rejects
//            illegal moves, and resolves win / draw / next turn from the
//            winner detector's win_line one cycle after each accepted move.
// Ports    : clk, rst (sync, active high), new_game (sync restart)
//            move_valid, move_pos[3:0]  -> move request (index 0..8)
//            move_ready                 <- high while waiting for a move
//            win_line[7:0]              -> detector result for ain/bin
//            ain[8:0], bin[8:0]         <- occupancy boards for A and B
//            turn, move_err, move_count[3:0], game_over, winner[1:0],
//            draw, win_line_q[7:0]      <- game status (all registered)
// Revision : 1.0 - initial release
// ============================================================================
module ttt_board_ctrl #(
  parameter bit FIRST_PLAYER = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [3:0] move_pos,
  output logic       move_ready,
  input  logic [7:0] win_line,
  output logic [8:0] ain,
  output logic [8:0] bin,
  output logic       turn,
  output logic       move_err,
  output logic [3:0] move_count,
  output logic       game_over,
  output logic [1:0] winner,
  output logic       draw,
  output logic [7:0] win_line_q
);

  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [8:0] pos_bit;     // one-hot square of move_pos; all zero for 9..15
  logic       move_legal;

  always_comb begin
    pos_bit = '0;
    for (int k = 0; k < 9; k++) begin
      pos_bit[k] = (move_pos == 4'(k));
    end
  end

  // An out-of-range index decodes to no square, so the range test is what
  // rejects it; the occupancy test catches squares already taken.
  assign move_legal = (move_pos <= 4'd8) && ((pos_bit & (ain | bin)) == 9'd0);

  assign move_ready = (state == PLAY);

  always_ff @(posedge clk) begin
    if (rst || new_game) begin
      state      <= PLAY;
      ain        <= '0;
      bin        <= '0;
      turn       <= FIRST_PLAYER;
      move_err   <= 1'b0;
      move_count <= '0;
      game_over  <= 1'b0;
      winner     <= 2'b00;
      draw       <= 1'b0;
      win_line_q <= '0;
    end else begin
      move_err <= 1'b0;
      case (state)
        PLAY: begin
          if (move_valid) begin
            if (move_legal) begin
              if (turn) bin <= bin | pos_bit;
              else      ain <= ain | pos_bit;
              move_count <= move_count + 4'd1;
              state      <= CHECK;
            end else begin
              move_err <= 1'b1;
            end
          end
        end
        CHECK: begin
          // A line completed on the 9th move is a win, not a draw.
          if (win_line != 8'd0) begin
            state      <= DONE;
            game_over  <= 1'b1;
            winner     <= turn ? 2'b10 : 2'b01;
            win_line_q <= win_line;
          end else if (move_count == 4'd9) begin
            state     <= DONE;
            game_over <= 1'b1;
            draw      <= 1'b1;
          end else begin
            turn  <= ~turn;
            state <= PLAY;
          end
        end
        DONE: begin
          // Outputs hold until rst or new_game.
        end
        default: state <= PLAY;
      endcase
    end
  end

endmodule
`default_nettype wire
